siso_serial_tx: RTL and testbench

Parallel-to-serial transmitter that drives the serial input of the team's SISO shift-register chain. It accepts one W-bit word through a valid/ready handshake and emits it one bit per clock, with frame-valid and last-bit markers. Back-to-back words produce a gapless bit stream. It is the producer end of the serial link whose consumer is the SISO register.

---
 rtl/siso_pkg.sv | 16 +
 rtl/siso_bit_counter.sv | 35 +++
 rtl/siso_serial_tx.sv | 122 ++++++++++++
 tb/tb_siso_serial_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and helpers for the SISO serial link.
package siso_pkg;

  localparam int unsigned SISO_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } tx_state_t;

  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/siso_bit_counter.sv
// Bit-position counter for the serial transmitter: clear-on-load up-counter
// that saturates at W-1 and flags the last and next-to-last positions.
module siso_bit_counter
  import siso_pkg::*;
#(
  parameter int unsigned W = SISO_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc,
  output logic o_pre_tc
);

  localparam int unsigned CW = cnt_w(W);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc     = (r_cnt == CW'(W - 1));
  assign o_tc     = w_tc;
  assign o_pre_tc = (r_cnt == CW'(W - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/siso_serial_tx.sv
// Parallel-to-serial transmitter feeding the SISO shift-register chain.
// Optional trailing even-parity bit when SISO_TX_PARITY_EN is defined.
module siso_serial_tx
  import siso_pkg::*;
#(
  parameter int unsigned W         = SISO_W_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_last,
  output logic         busy
);

`ifdef SISO_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  tx_state_t    r_state;
  logic [W-1:0] r_shift;
  logic         r_sout;
  logic         r_valid;
  logic         r_last;
`ifdef SISO_TX_PARITY_EN
  logic         r_par;
`endif

  logic         w_tc;
  logic         w_pre_tc;
  logic         w_accept;
  logic         w_end;
  logic         w_first_bit;
  logic         w_next_bit;
  logic [W-1:0] w_load_shift;
  logic [W-1:0] w_step_shift;

  // Shift register holds the not-yet-sent bits; sout already carries the current one.
  assign w_first_bit  = MSB_FIRST ? din[W-1] : din[0];
  assign w_load_shift = MSB_FIRST ? (din << 1) : (din >> 1);
  assign w_next_bit   = MSB_FIRST ? r_shift[W-1] : r_shift[0];
  assign w_step_shift = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  assign din_ready = (r_state == IDLE)
                   | ((r_state == SHIFT) & w_tc & !PARITY_EN)
                   | (r_state == PARITY);
  assign w_accept  = din_valid & din_ready;
  assign w_end     = (r_state == SHIFT) & w_tc;

  siso_bit_counter #(
    .W (W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_accept | w_end),
    .i_en     (r_state == SHIFT),
    .o_tc     (w_tc),
    .o_pre_tc (w_pre_tc)
  );

  // A handshake always wins: it can only fire in IDLE or on the final frame bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
`ifdef SISO_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shift <= w_load_shift;
      r_sout  <= w_first_bit;
      r_valid <= 1'b1;
      r_last  <= 1'b0;
`ifdef SISO_TX_PARITY_EN
      r_par   <= ^din;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (!w_tc) begin
            r_sout  <= w_next_bit;
            r_shift <= w_step_shift;
            r_last  <= w_pre_tc & !PARITY_EN;
          end else begin
`ifdef SISO_TX_PARITY_EN
            r_state <= PARITY;
            r_sout  <= r_par;
            r_last  <= 1'b1;
`else
            r_state <= IDLE;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_sout  <= 1'b0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign sout_last  = r_last;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_siso_serial_tx.sv
// Directed bench for siso_serial_tx (W=12, MSB first); covers the
// SISO_TX_PARITY_EN frame format when that macro is defined.
module tb_siso_serial_tx;

  localparam int unsigned W = 12;
`ifdef SISO_TX_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_last;
  logic         busy;

  int n_checks;
  int n_fail;

  siso_serial_tx #(
    .W         (W),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame bit i of word (MSB first, parity bit after the data).
  function automatic logic exp_bit(input logic [W-1:0] word, input int i);
    logic [W-1:0] w;
    w = word;
    if (i < int'(W)) return w[W-1-i];
    return ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic eb, input logic el, input logic er);
    chk({tag, ".sout"}, 32'(sout), 32'(eb));
    chk({tag, ".valid"}, 32'(sout_valid), 32'd1);
    chk({tag, ".last"}, 32'(sout_last), 32'(el));
    chk({tag, ".ready"}, 32'(din_ready), 32'(er));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".sout"}, 32'(sout), 32'd0);
    chk({tag, ".valid"}, 32'(sout_valid), 32'd0);
    chk({tag, ".last"}, 32'(sout_last), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".ready"}, 32'(din_ready), 32'd1);
  endtask

  // One-cycle valid pulse; returns in the first frame-bit cycle.
  task automatic send(input string tag, input logic [W-1:0] word);
    din       = word;
    din_valid = 1'b1;
    chk({tag, ".acc_ready"}, 32'(din_ready), 32'd1);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic frame_chk(input string tag, input logic [W-1:0] word);
    for (int i = 0; i < int'(FL); i++) begin
      step_chk($sformatf("%s[%0d]", tag, i), exp_bit(word, i),
               (i == int'(FL) - 1), (i == int'(FL) - 1));
    end
    idle_chk({tag, ".end"});
  endtask

  initial begin
    logic [W-1:0] b2b_word [2];
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    din       = '0;
    din_valid = 1'b0;

    // Reset held for 200 ns: outputs quiet throughout.
    for (int c = 0; c < 20; c++) begin
      #10;
      chk("rst.sout", 32'(sout), 32'd0);
      chk("rst.valid", 32'(sout_valid), 32'd0);
      chk("rst.last", 32'(sout_last), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
    end
    tick();
    reset = 1'b1;
    tick();
    idle_chk("post_rst");

    // Single word 12'b001111111111.
    send("single", 12'b0011_1111_1111);
    frame_chk("single", 12'b0011_1111_1111);
    tick();
    idle_chk("single.idle");

    // Back-to-back 12'h3FF then 12'h400 with valid held high.
    b2b_word[0] = 12'h3FF;
    b2b_word[1] = 12'h400;
    din       = b2b_word[0];
    din_valid = 1'b1;
    tick();
    din = b2b_word[1];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < int'(FL); i++) begin
        if (f == 1 && i == 0) din_valid = 1'b0;
        step_chk($sformatf("b2b%0d[%0d]", f, i), exp_bit(b2b_word[f], i),
                 (i == int'(FL) - 1), (i == int'(FL) - 1));
      end
    end
    idle_chk("b2b.end");

    // Busy rejection: 12'hAAA offered mid-frame of 12'h555.
    send("busy", 12'h555);
    for (int i = 0; i < int'(FL); i++) begin
      if (i == 4) begin
        din       = 12'hAAA;
        din_valid = 1'b1;
      end
      if (i == 5) din_valid = 1'b0;
      step_chk($sformatf("busy[%0d]", i), exp_bit(12'h555, i),
               (i == int'(FL) - 1), (i == int'(FL) - 1));
    end
    idle_chk("busy.end");
    tick();
    idle_chk("busy.noacc");

    // Reset asserted at bit 5 of 12'hFFF.
    send("midrst", 12'hFFF);
    for (int i = 0; i < 5; i++) begin
      step_chk($sformatf("midrst[%0d]", i), 1'b1, 1'b0, 1'b0);
    end
    chk("midrst.bit5", 32'(sout), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst.async_sout", 32'(sout), 32'd0);
    chk("midrst.async_valid", 32'(sout_valid), 32'd0);
    chk("midrst.async_last", 32'(sout_last), 32'd0);
    chk("midrst.async_busy", 32'(busy), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    idle_chk("midrst.rel");
    send("after_rst", 12'h801);
    frame_chk("after_rst", 12'h801);

`ifdef SISO_TX_PARITY_EN
    // 12'h007 has three ones, so the even-parity bit is 1.
    send("parity", 12'h007);
    for (int i = 0; i < int'(W); i++) begin
      step_chk($sformatf("parity[%0d]", i), (i >= 9), 1'b0, 1'b0);
    end
    step_chk("parity.pbit", 1'b1, 1'b1, 1'b1);
    idle_chk("parity.end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
